byteswap_arbiter: RTL

- Shared-resource controller for the 32-bit byte-reversal datapath.
- Arbitrates two valid/ready requesters onto one byte-swap unit using round-robin priority.
- Registers the result in a single-entry output stage with backpressure, tags each result with its source, and keeps per-requester accept counters.
- Sits between two word producers and one downstream consumer.

---
 rtl/byteswap_arbiter.sv | 64 ++++++
 1 files changed

// File: rtl/byteswap_arbiter.sv
// byteswap_arbiter: round-robin arbiter of two valid/ready requesters onto one
// 32-bit byte-reversal unit, with a registered single-entry output stage.
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in0_*/in1_*           - requester valid/data/ready handshakes
//   cfg_swap              - 1 = byte-reverse accepted word, 0 = pass through
//   out_valid/data/src    - registered result, its source requester
//   out_ready             - downstream accept
//   acc_cnt0/acc_cnt1     - per-requester accept counters (wrap)
module byteswap_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [31:0]      in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [31:0]      in1_data,
    output logic             in1_ready,
    input  logic             cfg_swap,
    output logic             out_valid,
    output logic [31:0]      out_data,
    output logic             out_src,
    input  logic             out_ready,
    output logic [CNT_W-1:0] acc_cnt0,
    output logic [CNT_W-1:0] acc_cnt1
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;
    state_t      state, state_nx;
    logic        last_grant, grant, can_accept, accept;
    logic [31:0] sel_data, res_data;
    always_comb begin
        grant      = (in0_valid && in1_valid) ? !last_grant : in1_valid;
        // a held result draining this cycle frees the stage for a same-cycle refill
        can_accept = (state == EMPTY) || out_ready;
        accept     = can_accept && (in0_valid || in1_valid);
        in0_ready  = accept && !grant;
        in1_ready  = accept && grant;
        sel_data   = grant ? in1_data : in0_data;
        res_data   = cfg_swap ? {sel_data[7:0], sel_data[15:8], sel_data[23:16], sel_data[31:24]} : sel_data;
        state_nx   = accept ? FULL : (out_ready ? EMPTY : state);
        out_valid  = (state == FULL);
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= EMPTY;
            out_data   <= '0;
            out_src    <= 1'b0;
            last_grant <= 1'b1;
            acc_cnt0   <= '0;
            acc_cnt1   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                out_data   <= res_data;
                out_src    <= grant;
                last_grant <= grant;
                if (grant) acc_cnt1 <= acc_cnt1 + CNT_W'(1);
                else acc_cnt0 <= acc_cnt0 + CNT_W'(1);
            end
        end
    end
endmodule
